// File: rtl/compare_pkg.sv
// compare_pkg: shared result codes and FSM state encodings for the serial nibble comparator.
package compare_pkg;
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/compare_slice4.sv
// compare_slice4: combinational 4-bit magnitude compare; equal nibbles pass the cascade input through.
module compare_slice4
    import compare_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] cas_i,
    output logic [2:0] res_o
);
    always_comb res_o = (a > b) ? CMP_GT : (a < b) ? CMP_LT : cas_i;
endmodule

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: walks two WIDTH-bit operands one nibble per clock, MSB first, returning a one-hot compare result.
// Optional SERIAL_CMP_EARLY_EXIT_EN: leave RUN as soon as the first unequal nibble is seen.
module serial_compare_ctrl
    import compare_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iCascade,
    output logic [2:0]       oData,
    output logic             oValid,
    input  logic             iAck,
    output logic             oBusy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       res_q, res_d, data_q, data_d, slice_res, step_res;
    logic             found_q, found_d, differ, done_now;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [3:0]       a_nib, b_nib;

    always_comb begin
        a_nib = a_q[{idx_q, 2'b00} +: 4];
        b_nib = b_q[{idx_q, 2'b00} +: 4];
    end

    // Running result is the cascade, so equal nibbles keep it and the first difference replaces it.
    compare_slice4 u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .cas_i (res_q),
        .res_o (slice_res)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        data_d   = data_q;
        found_d  = found_q;
        idx_d    = idx_q;
        differ   = a_nib != b_nib;
        step_res = found_q ? res_q : slice_res;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        done_now = (idx_q == '0) || differ;
`else
        done_now = idx_q == '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    a_d     = iData_a;
                    b_d     = iData_b;
                    res_d   = iCascade;
                    found_d = 1'b0;
                    idx_d   = LAST;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = step_res;
                found_d = found_q | differ;
                if (done_now) begin
                    data_d  = step_res;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: state_d = iAck ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            data_q  <= '0;
            found_q <= 1'b0;
            idx_q   <= LAST;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            data_q  <= data_d;
            found_q <= found_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        oReady = state_q == ST_IDLE;
        oBusy  = state_q == ST_RUN;
        oValid = state_q == ST_DONE;
        oData  = data_q;
    end
endmodule
